// File: rtl/eth_pkg.sv
// eth_pkg: shared widths and the TX arbiter state encoding.
//   ETH_ADDR_W   MAC buffer address / frame byte-count width
//   ETH_DATA_W   MAC buffer data width
//   tx_arb_state_t  arbiter FSM states
package eth_pkg;

  localparam int ETH_ADDR_W = 11;
  localparam int ETH_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    XMIT      = 3'd3,
    GAP       = 3'd4
  } tx_arb_state_t;

endpackage

// File: rtl/eth_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req    in   N       request vector
//   start  in   IW      first index to consider (search wraps N-1 -> 0)
//   gnt    out  N       one-hot winner (0 when no request)
//   idx    out  IW      winner index
//   any    out  1       at least one request present
module rr_picker #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(start) + i) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: shares the single eth MAC transmit port among N frame
// sources with round-robin, whole-frame grants.
//   clk, resetn                 clock, async active-low reset
//   req_vld   in  N             level request per source, held until req_ack
//   req_count in  N x 11        frame byte count, sampled at grant
//   req_ack   out N             grant pulse
//   req_done  out N             frame finished / abandoned pulse
//   req_err   out N             abandoned (MAC never went busy) pulse, with req_done
//   req_adv   out N             MAC read strobe steered to the granted source
//   req_addr  out 11            MAC read address, broadcast
//   req_data  in  N x 8         per-source buffer read data
//   tx_vld    out 1             frame launch pulse to the MAC
//   tx_count  out 11            byte count of the granted frame
//   tx_addr, tx_adv, tx_busy, tx_last   MAC read side / status
//   tx_data   out 8             granted source's data, combinational
// Build option: define ETH_TX_ARB_IFG_EN to enforce IFG_CYC idle cycles
// (GAP state) after every completed frame.
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int N        = 2,
  parameter int BUSY_TMO = 64,
  parameter int IFG_CYC  = 96
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [N-1:0]                        req_vld,
  input  logic [N-1:0][ETH_ADDR_W-1:0]        req_count,
  output logic [N-1:0]                        req_ack,
  output logic [N-1:0]                        req_done,
  output logic [N-1:0]                        req_err,
  output logic [N-1:0]                        req_adv,
  output logic [ETH_ADDR_W-1:0]               req_addr,
  input  logic [N-1:0][ETH_DATA_W-1:0]        req_data,
  output logic                                tx_vld,
  output logic [ETH_ADDR_W-1:0]               tx_count,
  input  logic [ETH_ADDR_W-1:0]               tx_addr,
  input  logic                                tx_adv,
  input  logic                                tx_busy,
  input  logic                                tx_last,
  output logic [ETH_DATA_W-1:0]               tx_data
);

  localparam int IW   = $clog2(N);
  localparam int TMAX = (BUSY_TMO > IFG_CYC) ? BUSY_TMO : IFG_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  tx_arb_state_t           state_q;
  logic [N-1:0]            gnt_q;      // one-hot grant, held until back in IDLE
  logic [IW-1:0]           gidx_q;
  logic [IW-1:0]           ptr_q;      // next index searched first
  logic [TW-1:0]           tmr_q;      // busy timeout and IFG gap share this
  logic                    tx_vld_q;
  logic [ETH_ADDR_W-1:0]   tx_count_q;
  logic [N-1:0]            ack_q, done_q, err_q;

  logic [N-1:0]            pk_gnt;
  logic [IW-1:0]           pk_idx;
  logic                    pk_any;

  // Completion is taken from tx_busy falling; tx_last carries no control.
  logic unused_tx_last;
  assign unused_tx_last = tx_last;

  rr_picker #(.N(N)) u_pick (
    .req   (req_vld),
    .start (ptr_q),
    .gnt   (pk_gnt),
    .idx   (pk_idx),
    .any   (pk_any)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      tmr_q      <= '0;
      tx_vld_q   <= 1'b0;
      tx_count_q <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
    end else begin
      tx_vld_q <= 1'b0;
      ack_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      case (state_q)
        IDLE: begin
          if (pk_any && !tx_busy) begin
            state_q    <= LAUNCH;
            gnt_q      <= pk_gnt;
            gidx_q     <= pk_idx;
            ptr_q      <= (pk_idx == IW'(N - 1)) ? '0 : pk_idx + IW'(1);
            tx_count_q <= req_count[pk_idx];
            ack_q      <= pk_gnt;
            // A zero-length frame never reaches the MAC.
            tx_vld_q   <= (req_count[pk_idx] != '0);
          end
        end
        LAUNCH: begin
          tmr_q <= '0;
          if (tx_count_q == '0) begin
            done_q  <= gnt_q;
            gnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            state_q <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= XMIT;
          end else if (tmr_q == TW'(BUSY_TMO - 1)) begin
            // MAC never picked the frame up: abandon it, no gap.
            done_q  <= gnt_q;
            err_q   <= gnt_q;
            gnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        XMIT: begin
          if (!tx_busy) begin
            done_q <= gnt_q;
            tmr_q  <= '0;
`ifdef ETH_TX_ARB_IFG_EN
            state_q <= GAP;
`else
            gnt_q   <= '0;
            state_q <= IDLE;
`endif
          end
        end
`ifdef ETH_TX_ARB_IFG_EN
        GAP: begin
          if (tmr_q == TW'(IFG_CYC - 1)) begin
            gnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_adv = '0;
    tx_data = '0;
    if (state_q == XMIT) begin
      req_adv = gnt_q & {N{tx_adv}};
      tx_data = req_data[gidx_q];
    end
  end

  assign req_addr = tx_addr;
  assign req_ack  = ack_q;
  assign req_done = done_q;
  assign req_err  = err_q;
  assign tx_vld   = tx_vld_q;
  assign tx_count = tx_count_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: table-driven request vectors plus hand-written corner
// sequences; expected grants are queued when requests are raised and popped
// when the arbiter launches a frame. The bench plays MAC and frame buffers.
module tb_eth_tx_arbiter;

  localparam int N   = 2;
  localparam int TMO = 16;
  localparam int IFG = 12;
`ifdef ETH_TX_ARB_IFG_EN
  localparam int GAP_EXP = IFG + 2;
`else
  localparam int GAP_EXP = 2;
`endif

  logic                clk = 1'b0;
  logic                resetn;
  logic [N-1:0]        req_vld;
  logic [N-1:0][10:0]  req_cnt;
  logic [N-1:0]        req_ack, req_done, req_err, req_adv;
  logic [10:0]         req_addr;
  logic [N-1:0][7:0]   req_data;
  logic                tx_vld;
  logic [10:0]         tx_count;
  logic [10:0]         tx_addr;
  logic                tx_adv, tx_busy, tx_last;
  logic [7:0]          tx_data;

  eth_tx_arbiter #(.N(N), .BUSY_TMO(TMO), .IFG_CYC(IFG)) dut (
    .clk(clk), .resetn(resetn), .req_vld(req_vld), .req_count(req_cnt),
    .req_ack(req_ack), .req_done(req_done), .req_err(req_err), .req_adv(req_adv),
    .req_addr(req_addr), .req_data(req_data), .tx_vld(tx_vld), .tx_count(tx_count),
    .tx_addr(tx_addr), .tx_adv(tx_adv), .tx_busy(tx_busy), .tx_last(tx_last),
    .tx_data(tx_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] fdat(input int s, input int a);
    return 8'((s * 37 + a) ^ 8'h5A);
  endfunction

  // Frame buffers answer the broadcast address with a per-source pattern.
  always_comb begin
    req_data = '0;
    for (int s = 0; s < N; s++) req_data[s] = fdat(s, int'(req_addr));
  end

  typedef struct { int src; int cnt; } exp_t;
  typedef struct { logic [1:0] mask; int c0; int c1; int first; int second; } vec_t;

  exp_t q[$];
  vec_t tbl[7];
  int   total = 0, bad = 0, cyc = 0, last_fall = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic push(input int s, input int c);
    exp_t e;
    e.src = s; e.cnt = c;
    q.push_back(e);
  endtask

  // One full frame as the MAC sees it; pops the expected grant.
  task automatic serve(input bit chk_gap, input logic [1:0] late, input logic [1:0] rereq);
    exp_t e;
    int t, nadv, nbad;
    if (q.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = q.pop_front();
    t = 0;
    do begin tick(); t++; end while (!tx_vld && t < 400);
    if (!tx_vld) begin
      chk("launch_wait", 0, 1);
      return;
    end
    if (chk_gap) chk("gap", cyc - last_fall, GAP_EXP);
    chk("ack", req_ack, 32'(1) << e.src);
    chk("tx_count", tx_count, e.cnt);
    req_vld[e.src] = 1'b0;
    req_vld = req_vld | late;
    tick();
    chk("vld_pulse", tx_vld, 0);
    tick();
    tx_busy = 1'b1;
    nadv = 0; nbad = 0;
    for (int a = 0; a < e.cnt; a++) begin
      tick();
      tx_addr = 11'(a); tx_adv = 1'b1; tx_last = (a == e.cnt - 1);
      #1;
      if (req_adv == 2'(1 << e.src)) nadv++;
      if (tx_data !== fdat(e.src, a)) nbad++;
    end
    tick();
    tx_adv = 1'b0; tx_last = 1'b0;
    chk("adv_cnt", nadv, e.cnt);
    chk("data_bad", nbad, 0);
    tick();
    tx_busy = 1'b0;
    last_fall = cyc;
    tick();
    chk("done", req_done, 32'(1) << e.src);
    chk("err", req_err, 0);
    req_vld = req_vld | rereq;
  endtask

  initial begin
    int k;
    tbl[0] = '{2'b11, 60,   42,  0,  1};
    tbl[1] = '{2'b11, 5,    7,   0,  1};
    tbl[2] = '{2'b10, 0,    3,   1, -1};
    tbl[3] = '{2'b01, 60,   0,   0, -1};
    tbl[4] = '{2'b11, 1,    2,   1,  0};
    tbl[5] = '{2'b10, 0,    255, 1, -1};
    tbl[6] = '{2'b01, 2047, 0,   0, -1};

    resetn = 1'b0; req_vld = '0; req_cnt = '0; tx_addr = '0;
    tx_adv = 1'b1; tx_busy = 1'b0; tx_last = 1'b0;
    repeat (3) tick();
    #1;
    chk("rst_vld", tx_vld, 0);
    chk("rst_count", tx_count, 0);
    chk("rst_pulses", {req_ack, req_done, req_err}, 0);
    chk("rst_adv", req_adv, 0);
    chk("rst_data", tx_data, 0);
    tick();
    tx_adv = 1'b0; resetn = 1'b1;

    foreach (tbl[i]) begin
      req_cnt[0] = 11'(tbl[i].c0);
      req_cnt[1] = 11'(tbl[i].c1);
      push(tbl[i].first, tbl[i].first == 0 ? tbl[i].c0 : tbl[i].c1);
      if (tbl[i].second >= 0) push(tbl[i].second, tbl[i].second == 0 ? tbl[i].c0 : tbl[i].c1);
      req_vld = tbl[i].mask;
      serve(1'b0, 2'b00, 2'b00);
      if (tbl[i].second >= 0) serve(1'b1, 2'b00, 2'b00);
    end

    // MAC never goes busy: abandon after the timeout, then serve the next one.
    req_cnt[1] = 11'd10; req_vld = 2'b10;
    k = 0;
    do begin tick(); k++; end while (!tx_vld && k < 400);
    chk("tmo_ack", req_ack, 2'b10);
    req_vld = 2'b00;
    k = 0;
    do begin tick(); k++; end while (req_done == '0 && k < 200);
    chk("tmo_lat", k, TMO + 1);
    chk("tmo_done", req_done, 2'b10);
    chk("tmo_err", req_err, 2'b10);
    req_cnt[0] = 11'd4; push(0, 4); req_vld = 2'b01;
    serve(1'b0, 2'b00, 2'b00);

    // Zero-length frame: ack then done, MAC untouched.
    req_cnt[0] = 11'd0; req_vld = 2'b01;
    tick();
    chk("zero_ack", {req_ack, tx_vld}, {2'b01, 1'b0});
    req_vld = 2'b00;
    tick();
    chk("zero_done", {req_done, req_err, tx_vld}, {2'b01, 2'b00, 1'b0});
    tick();
    chk("zero_novld", {req_ack, tx_vld}, 0);

    // Busy MAC in IDLE blocks grants.
    tx_busy = 1'b1; req_cnt[1] = 11'd6; req_vld = 2'b10; push(1, 6);
    k = 0;
    repeat (6) begin tick(); if (req_ack != '0) k++; end
    chk("busy_block", k, 0);
    tx_busy = 1'b0;
    serve(1'b0, 2'b00, 2'b00);

    // src1 keeps re-requesting; src0 asks once mid-frame and must go next.
    req_cnt[0] = 11'd8; req_cnt[1] = 11'd9; req_vld = 2'b10;
    push(1, 9); push(0, 8); push(1, 9);
    serve(1'b0, 2'b01, 2'b10);
    serve(1'b1, 2'b00, 2'b00);
    serve(1'b1, 2'b00, 2'b00);

    // Reset in the middle of a transfer.
    req_cnt[0] = 11'd20; req_vld = 2'b01;
    k = 0;
    do begin tick(); k++; end while (!tx_vld && k < 400);
    chk("mid_ack", req_ack, 2'b01);
    req_vld = 2'b00;
    tick();
    tick(); tx_busy = 1'b1;
    tick(); tx_adv = 1'b1; tx_addr = 11'd3;
    #1;
    chk("mid_pre_adv", req_adv, 2'b01);
    resetn = 1'b0;
    #1;
    chk("mid_rst_vld", tx_vld, 0);
    chk("mid_rst_count", tx_count, 0);
    chk("mid_rst_adv", req_adv, 0);
    chk("mid_rst_data", tx_data, 0);
    chk("mid_rst_pulses", {req_ack, req_done, req_err}, 0);
    tick();
    tx_adv = 1'b0; tx_busy = 1'b0; resetn = 1'b1;
    k = 0;
    repeat (4) begin tick(); if (req_done != '0) k++; end
    chk("mid_no_done", k, 0);
    req_cnt[1] = 11'd5; push(1, 5); req_vld = 2'b10;
    serve(1'b0, 2'b00, 2'b00);
    chk("sb_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
